// File: rtl/onc_fetch_unit.sv
// onc_fetch_unit: ONC-16 instruction-fetch front end.
// Address generator, one-deep in-flight request tracker and a DEPTH-entry
// prefetch FIFO between synchronous instruction memory and decode.
module onc_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                INST_W   = 16,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clock,
    input  logic                       n_rst,
    output logic [ADDR_W-1:0]          imem_addr,
    output logic                       imem_re,
    input  logic [INST_W-1:0]          imem_din,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    input  logic                       id_ready,
    output logic                       id_valid,
    output logic [INST_W-1:0]          id_inst,
    output logic [ADDR_W-1:0]          id_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic              req_q;
    logic [ADDR_W-1:0] req_pc;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  cnt_q;
    entry_t            mem [DEPTH];

    logic [CNT_W-1:0]  occ;
    logic              push;
    logic              pop;

    // Issue/capture/pop decisions; the issue check deliberately ignores a
    // same-cycle pop so the request path stays short.
    always_comb begin
        occ       = cnt_q + CNT_W'(req_q);
        imem_re   = !redirect && (occ < CNT_W'(DEPTH));
        push      = req_q && !redirect;
        pop       = id_valid && id_ready && !redirect;
        imem_addr = fetch_pc;
    end

    assign id_valid = (cnt_q != '0);
    assign id_inst  = mem[rd_ptr].inst;
    assign id_pc    = mem[rd_ptr].pc;
    assign count    = cnt_q;

    // Fetch address, in-flight tracking, pointers and occupancy; redirect
    // wins over issue, capture and pop in the same cycle.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            fetch_pc <= RESET_PC;
            req_q    <= 1'b0;
            req_pc   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt_q    <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            req_q    <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt_q    <= '0;
        end else begin
            if (imem_re) begin
                req_q    <= 1'b1;
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + ADDR_W'(1);
            end else begin
                req_q    <= 1'b0;
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
            else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // FIFO storage: the returning word is tagged with the PC it was fetched from.
    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= '{inst: imem_din, pc: req_pc};
        end
    end

endmodule
